// File: rtl/zap_ram_rd_stream_pkg.sv
// Shared constants and helpers for the zap_ram read-stream front-end.
// RD_LAT is the fixed read latency of the zap_ram_simple pipeline.
package zap_ram_rd_pkg;

   localparam int RD_LAT = 3;

   typedef logic [RD_LAT-1:0] vld_t;
   typedef logic [2:0]        inflight_t;

   // Count register width for a FIFO of 'depth' entries (holds 0..depth inclusive).
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic [1:0] popcount3(input vld_t v);
      return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
   endfunction

endpackage

// File: rtl/zap_ram_rd_stream_if.sv
// Bus bundle between a requester/consumer, the read-stream block and the RAM.
// slave is the read-stream block's view; master is the surrounding logic's view.
interface zap_ram_rd_stream_if
   import zap_ram_rd_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AW    = 5
) ();

   logic             i_rd_valid;
   logic [AW-1:0]    i_rd_addr;
   logic             o_rd_ready;
   logic             i_wr_en;
   logic [AW-1:0]    i_wr_addr;
   logic [WIDTH-1:0] i_wr_data;
   logic             o_ram_wr_en;
   logic [AW-1:0]    o_ram_wr_addr;
   logic [WIDTH-1:0] o_ram_wr_data;
   logic [AW-1:0]    o_ram_rd_addr;
   logic [WIDTH-1:0] i_ram_rd_data;
   logic             o_data_valid;
   logic [WIDTH-1:0] o_data;
   logic             i_data_ready;
   inflight_t        o_inflight;

   modport slave (
      input  i_rd_valid, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
      input  i_ram_rd_data, i_data_ready,
      output o_rd_ready, o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data,
      output o_ram_rd_addr, o_data_valid, o_data, o_inflight
   );

   modport master (
      output i_rd_valid, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
      output i_ram_rd_data, i_data_ready,
      input  o_rd_ready, o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data,
      input  o_ram_rd_addr, o_data_valid, o_data, o_inflight
   );

endinterface

// File: rtl/zap_ram_rd_stream_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on o_data while o_valid.
// Storage is deliberately left out of reset; only pointers and count clear.
module zap_fwft_fifo
   import zap_ram_rd_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = fifo_cnt_w(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic [CW-1:0]    o_count
);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             full, push_ok, pop_ok;

   always_comb begin
      full     = (count_q == CW'(DEPTH));
      pop_ok   = i_pop & (count_q != '0);
      // A pop in the same cycle frees the slot, so a full FIFO may still accept.
      push_ok  = i_push & (~full | pop_ok);
      wr_ptr_d = wr_ptr_q + PW'(push_ok);
      rd_ptr_d = rd_ptr_q + PW'(pop_ok);
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_valid = (count_q != '0);
   assign o_count = count_q;

endmodule

// File: rtl/zap_ram_rd_stream.sv
// Valid/ready read front-end for the fixed-latency zap_ram pipeline: issues reads,
// tracks them in a valid pipe and lands returned data in a credit-protected FWFT FIFO.
module zap_ram_rd_stream
   import zap_ram_rd_pkg::*;
#(
   parameter  int WIDTH      = 32,
   parameter  int DEPTH      = 32,
   parameter  int FIFO_DEPTH = 4,
   localparam int AW         = $clog2(DEPTH),
   localparam int CW         = fifo_cnt_w(FIFO_DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   zap_ram_rd_stream_if.slave bus
);

   vld_t             vld_q, vld_d;
   logic             issue, rd_ready;
   logic             fifo_push, fifo_pop, fifo_valid;
   logic [WIDTH-1:0] fifo_data;
   logic [CW-1:0]    fifo_count;
   logic [CW:0]      occupancy;
   logic [1:0]       inflight;

   if (FIFO_DEPTH < RD_LAT + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("zap_ram_rd_stream: FIFO_DEPTH must be a power of two and >= RD_LAT+1");
   end

   // Every issued read owns a FIFO slot from issue until it is popped, so the
   // RAM pipeline can never deliver a word with nowhere to land it.
   always_comb begin
      inflight  = popcount3(vld_q);
      occupancy = {1'b0, fifo_count} + (CW+1)'(inflight);
      rd_ready  = (occupancy < (CW+1)'(FIFO_DEPTH)) & ~i_reset;
      issue     = bus.i_rd_valid & rd_ready;
      vld_d     = {vld_q[RD_LAT-2:0], issue};
      fifo_push = vld_q[RD_LAT-1];
      fifo_pop  = fifo_valid & bus.i_data_ready;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   zap_fwft_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (fifo_push),
      .i_data  (bus.i_ram_rd_data),
      .i_pop   (fifo_pop),
      .o_data  (fifo_data),
      .o_valid (fifo_valid),
      .o_count (fifo_count)
   );

   assign bus.o_rd_ready    = rd_ready;
   assign bus.o_ram_wr_en   = bus.i_wr_en & ~i_reset;
   assign bus.o_ram_wr_addr = bus.i_wr_addr;
   assign bus.o_ram_wr_data = bus.i_wr_data;
   assign bus.o_ram_rd_addr = AW'(bus.i_rd_addr);
   assign bus.o_data_valid  = fifo_valid;
   assign bus.o_data        = fifo_valid ? fifo_data : '0;
   assign bus.o_inflight    = inflight_t'(inflight);

   ovf_never: assert property (@(posedge i_clk) disable iff (i_reset)
      !(fifo_push && fifo_count == CW'(FIFO_DEPTH) && !fifo_pop));

endmodule

// File: tb/tb_zap_ram_rd_stream.sv
// Bench for zap_ram_rd_stream with a 3-cycle write-first RAM model behind it.
// Directed table of single reads plus hand sequences for streaming, stalls, collisions and reset.
module tb_zap_ram_rd_stream;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int FD    = 4;

   typedef struct {
      logic [AW-1:0]    wr_addr;
      logic [WIDTH-1:0] wr_data;
      logic [AW-1:0]    rd_addr;
      logic [WIDTH-1:0] exp_data;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   zap_ram_rd_stream_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   zap_ram_rd_stream #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .FIFO_DEPTH (FD)
   ) u_dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // RAM model: address register, array read (write-first), output register.
   logic [WIDTH-1:0] ram_mem [DEPTH];
   logic [AW-1:0]    ram_a1;
   logic [WIDTH-1:0] ram_d2, ram_d3;

   always @(posedge clk) begin
      if (bus.o_ram_wr_en) ram_mem[bus.o_ram_wr_addr] <= bus.o_ram_wr_data;
      ram_a1 <= bus.o_ram_rd_addr;
      ram_d2 <= (bus.o_ram_wr_en && bus.o_ram_wr_addr == ram_a1) ? bus.o_ram_wr_data : ram_mem[ram_a1];
      ram_d3 <= ram_d2;
   end

   assign bus.i_ram_rd_data = ram_d3;

   int               n_checks = 0;
   int               n_pass   = 0;
   int               n_issued = 0;
   int               n_popped = 0;
   int               cyc      = 0;
   int               max_out  = 0;
   int               first_issue_cyc = -1;
   int               first_beat_cyc  = -1;
   logic [WIDTH-1:0] shadow [DEPTH];
   logic [WIDTH-1:0] exp_q [$];
   logic             use_fixed = 1'b0;
   logic [WIDTH-1:0] fixed_exp = '0;
   vec_t             vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Evaluates this cycle's handshakes, then advances to 1ns after the next edge.
   task automatic tick();
      int               outst;
      logic [WIDTH-1:0] e;
      outst = n_issued - n_popped;
      if (!rst) chk("ready_credit", 32'(bus.o_rd_ready), 32'(outst < FD));
      if (bus.i_rd_valid && bus.o_rd_ready) begin
         exp_q.push_back(use_fixed ? fixed_exp : shadow[bus.i_rd_addr]);
         if (first_issue_cyc < 0) first_issue_cyc = cyc;
         n_issued++;
      end
      if (bus.o_data_valid && bus.i_data_ready) begin
         if (first_beat_cyc < 0) first_beat_cyc = cyc;
         n_popped++;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL beat_unexpected: got %h, required no beat (cycle %0d)", bus.o_data, cyc);
         end else begin
            e = exp_q.pop_front();
            $display("beat cycle=%0d data=%h expected=%h", cyc, bus.o_data, e);
            chk("beat_data", bus.o_data, e);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      outst = n_issued - n_popped;
      if (outst > max_out) max_out = outst;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      bus.i_wr_en   = 1'b1;
      bus.i_wr_addr = a;
      bus.i_wr_data = d;
      #1;
      chk("wr_passthru_en", 32'(bus.o_ram_wr_en), 32'd1);
      chk("wr_passthru_data", bus.o_ram_wr_data, d);
      shadow[a] = d;
      tick();
      bus.i_wr_en = 1'b0;
   endtask

   task automatic drain(input int bound);
      bus.i_rd_valid   = 1'b0;
      bus.i_data_ready = 1'b1;
      for (int t = 0; t < bound && exp_q.size() != 0; t++) tick();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      chk("drain_valid", 32'(bus.o_data_valid), 32'd0);
      bus.i_data_ready = 1'b0;
   endtask

   // One read into an empty FIFO; checks the 4-cycle latency and in-flight profile.
   task automatic single_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] e);
      use_fixed        = 1'b1;
      fixed_exp        = e;
      bus.i_data_ready = 1'b0;
      bus.i_rd_valid   = 1'b1;
      bus.i_rd_addr    = a;
      chk("issue_ready", 32'(bus.o_rd_ready), 32'd1);
      tick();
      bus.i_rd_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk("inflight", 32'(bus.o_inflight), (k < 4) ? 32'd1 : 32'd0);
         chk("head_valid", 32'(bus.o_data_valid), (k == 4) ? 32'd1 : 32'd0);
         if (k == 3) chk("data_gated", bus.o_data, 32'd0);
         if (k < 4) tick();
      end
      chk("head_data", bus.o_data, e);
      bus.i_data_ready = 1'b1;
      tick();
      bus.i_data_ready = 1'b0;
      use_fixed        = 1'b0;
      chk("after_pop_valid", 32'(bus.o_data_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_i;
      int base_p;

      vecs[0] = '{5'd5,  32'hDEADBEEF, 5'd5,  32'hDEADBEEF};
      vecs[1] = '{5'd0,  32'h0000_0001, 5'd0,  32'h0000_0001};
      vecs[2] = '{5'd31, 32'hA5A5_5A5A, 5'd31, 32'hA5A5_5A5A};
      vecs[3] = '{5'd7,  32'h1234_5678, 5'd5,  32'hDEADBEEF};

      rst              = 1'b1;
      bus.i_rd_valid   = 1'b0;
      bus.i_rd_addr    = '0;
      bus.i_wr_en      = 1'b1;
      bus.i_wr_addr    = '0;
      bus.i_wr_data    = '0;
      bus.i_data_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.o_rd_ready), 32'd0);
      chk("rst_valid", 32'(bus.o_data_valid), 32'd0);
      chk("rst_inflight", 32'(bus.o_inflight), 32'd0);
      chk("rst_data", bus.o_data, 32'd0);
      chk("rst_wr_en", 32'(bus.o_ram_wr_en), 32'd0);
      bus.i_wr_en = 1'b0;
      rst         = 1'b0;
      #1;
      chk("first_ready", 32'(bus.o_rd_ready), 32'd1);

      // Table of single reads: write, settle, read back with latency checks.
      for (int i = 0; i < 4; i++) begin
         wr(vecs[i].wr_addr, vecs[i].wr_data);
         idle(3);
         single_read(vecs[i].rd_addr, vecs[i].exp_data);
      end

      // Burst of 8 reads with the consumer always ready.
      for (int i = 0; i < 8; i++) wr(5'(i), 32'h100 + 32'(i));
      idle(1);
      first_issue_cyc  = -1;
      first_beat_cyc   = -1;
      base_i           = n_issued;
      base_p           = n_popped;
      bus.i_data_ready = 1'b1;
      bus.i_rd_valid   = 1'b1;
      bus.i_rd_addr    = '0;
      for (int t = 0; t < 40 && (n_issued - base_i) < 8; t++) begin
         tick();
         bus.i_rd_addr = 5'(n_issued - base_i);
      end
      bus.i_rd_valid = 1'b0;
      chk("burst_issued", 32'(n_issued - base_i), 32'd8);
      drain(20);
      chk("burst_beats", 32'(n_popped - base_p), 32'd8);
      chk("first_beat_latency", 32'(first_beat_cyc - first_issue_cyc), 32'd4);

      // Consumer stalled: credits run out at FIFO_DEPTH, then resume.
      base_i           = n_issued;
      bus.i_data_ready = 1'b0;
      bus.i_rd_valid   = 1'b1;
      bus.i_rd_addr    = '0;
      for (int t = 0; t < 12; t++) begin
         tick();
         bus.i_rd_addr = 5'((n_issued - base_i) % 8);
      end
      chk("stall_accepts", 32'(n_issued - base_i), 32'd4);
      chk("stall_ready", 32'(bus.o_rd_ready), 32'd0);
      chk("stall_inflight", 32'(bus.o_inflight), 32'd0);
      chk("stall_valid", 32'(bus.o_data_valid), 32'd1);
      bus.i_data_ready = 1'b1;
      for (int t = 0; t < 30 && (n_issued - base_i) < 6; t++) begin
         tick();
         bus.i_rd_addr = 5'((n_issued - base_i) % 8);
      end
      chk("stall_resume", 32'(n_issued - base_i), 32'd6);
      drain(20);

      // Same-cycle write/read collision, then write one cycle after the read.
      wr(5'd3, 32'h22);
      idle(3);
      use_fixed        = 1'b1;
      fixed_exp        = 32'h11;
      bus.i_data_ready = 1'b0;
      bus.i_wr_en      = 1'b1;
      bus.i_wr_addr    = 5'd3;
      bus.i_wr_data    = 32'h11;
      bus.i_rd_valid   = 1'b1;
      bus.i_rd_addr    = 5'd3;
      chk("coll_ready", 32'(bus.o_rd_ready), 32'd1);
      tick();
      bus.i_wr_en    = 1'b0;
      bus.i_rd_valid = 1'b0;
      use_fixed      = 1'b0;
      shadow[3]      = 32'h11;
      drain(10);
      use_fixed      = 1'b1;
      fixed_exp      = 32'h33;
      bus.i_rd_valid = 1'b1;
      bus.i_rd_addr  = 5'd3;
      tick();
      bus.i_rd_valid = 1'b0;
      use_fixed      = 1'b0;
      bus.i_wr_en    = 1'b1;
      bus.i_wr_addr  = 5'd3;
      bus.i_wr_data  = 32'h33;
      tick();
      bus.i_wr_en = 1'b0;
      shadow[3]   = 32'h33;
      drain(10);
      single_read(5'd3, 32'h33);

      // Steady state at full occupancy with an alternating consumer.
      base_i         = n_issued;
      base_p         = n_popped;
      max_out        = 0;
      bus.i_rd_valid = 1'b1;
      bus.i_rd_addr  = '0;
      for (int t = 0; t < 40; t++) begin
         bus.i_data_ready = (t % 2) == 1;
         tick();
         bus.i_rd_addr = 5'((n_issued - base_i) % 8);
      end
      bus.i_rd_valid = 1'b0;
      drain(30);
      chk("steady_max_outstanding", 32'(max_out), 32'd4);
      chk("steady_no_loss", 32'(n_popped - base_p), 32'(n_issued - base_i));

      // Reset with reads in flight and buffered.
      bus.i_data_ready = 1'b0;
      bus.i_rd_valid   = 1'b1;
      bus.i_rd_addr    = 5'd2;
      for (int t = 0; t < 4; t++) tick();
      chk("pre_rst_inflight", 32'(bus.o_inflight), 32'd3);
      chk("pre_rst_valid", 32'(bus.o_data_valid), 32'd1);
      chk("pre_rst_ready", 32'(bus.o_rd_ready), 32'd0);
      #2;
      rst            = 1'b1;
      bus.i_rd_valid = 1'b0;
      bus.i_wr_en    = 1'b1;
      bus.i_wr_addr  = 5'd9;
      bus.i_wr_data  = 32'hBAD0_BAD0;
      #1;
      chk("async_rst_valid", 32'(bus.o_data_valid), 32'd0);
      chk("async_rst_ready", 32'(bus.o_rd_ready), 32'd0);
      chk("async_rst_inflight", 32'(bus.o_inflight), 32'd0);
      chk("async_rst_data", bus.o_data, 32'd0);
      chk("async_rst_wr_en", 32'(bus.o_ram_wr_en), 32'd0);
      bus.i_wr_en = 1'b0;
      exp_q.delete();
      n_issued = 0;
      n_popped = 0;
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(bus.o_rd_ready), 32'd1);
      chk("post_rst_inflight", 32'(bus.o_inflight), 32'd0);
      bus.i_data_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         tick();
         chk("no_stale_beat", 32'(bus.o_data_valid), 32'd0);
      end
      single_read(5'd1, 32'h101);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
